// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with a 2-flop input synchronizer, a 3-sample
//             majority vote around mid-bit, a framing-error strobe and a
//             break-absorbing wait state.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       received,
  output logic       frame_err,
  output logic       busy
);

  // Bit-timer landmarks. The vote takes line values at MID-1 and MID and
  // the live line value at MID+1, where the decision is made.
  localparam logic [15:0] LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MID    = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] MID_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] MID_P1 = 16'(CLKS_PER_BIT / 2 + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        sync1;
  logic        sync2;
  logic        line;
  logic [15:0] timer;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        samp_a;
  logic        samp_b;
  logic        vote;
  logic        decide;
  logic        wrap;

  assign line   = sync2;
  assign decide = (timer == MID_P1);
  assign wrap   = (timer == LAST);
  assign vote   = (samp_a & samp_b) | (samp_a & line) | (samp_b & line);
  assign busy   = (state != IDLE);

  // Two-flop synchronizer; both flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!line) begin
          state_next = START;
        end
      end
      START: begin
        if (decide && vote) begin
          state_next = IDLE;
        end else if (wrap) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (wrap && (bit_cnt == 3'd7)) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          state_next = vote ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (line) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timer. The IDLE cycle that spots the low line is already one clock
  // into the start bit, so START begins at 1 to keep samples centred.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= 16'd0;
    end else begin
      case (state)
        IDLE:              timer <= line ? 16'd0 : 16'd1;
        START, DATA, STOP: timer <= wrap ? 16'd0 : timer + 16'd1;
        default:           timer <= 16'd0;
      endcase
    end
  end

  // Bit counter: cleared on start detection, advanced at each data-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
    end else if ((state == IDLE) && !line) begin
      bit_cnt <= 3'd0;
    end else if ((state == DATA) && wrap) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Capture the two early vote samples of every bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (timer == MID_M1) begin
        samp_a <= line;
      end
      if (timer == MID) begin
        samp_b <= line;
      end
    end
  end

  // Shift register: data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= 8'h00;
    end else if ((state == DATA) && decide) begin
      shreg <= {vote, shreg[7:1]};
    end
  end

  // Output byte and strobes, all decided at the stop-bit vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte   <= 8'h00;
      received  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      received  <= 1'b0;
      frame_err <= 1'b0;
      if ((state == STOP) && decide) begin
        if (vote) begin
          rx_byte  <= shreg;
          received <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx at 16 clocks per bit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_byte;
  logic       received;
  logic       frame_err;
  logic       busy;

  int   checks = 0;
  int   passed = 0;

  int   cyc = 0;
  int   rcv_cnt = 0;
  int   fe_cnt = 0;
  int   busy_cyc = 0;
  int   viol = 0;
  int   last_rcv_cyc = 0;
  logic [7:0] got [0:63];
  logic prev_strobe = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .received  (received),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (received) begin
      if (rcv_cnt < 64) got[rcv_cnt] = rx_byte;
      rcv_cnt = rcv_cnt + 1;
      last_rcv_cyc = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (received && frame_err) viol = viol + 1;
    if ((received || frame_err) && prev_strobe) viol = viol + 1;
    prev_strobe = received | frame_err;
    if (busy) busy_cyc = busy_cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed = passed + 1;
  endtask

  // Drive one 8N1 frame; spike_bit >= 0 inverts rx for one clock mid data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int spike_bit);
    logic b;
    for (int i = 0; i < 10; i++) begin
      b = (i == 0) ? 1'b0 : ((i == 9) ? stop_bit : d[i-1]);
      for (int c = 0; c < CPB; c++) begin
        rx = ((i - 1 == spike_bit) && (c == CPB / 2)) ? ~b : b;
        @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    if (rx_byte !== 8'h00) begin checks++; $display("FAIL reset_rx_byte: got %0h expected 0", rx_byte); end else begin checks++; passed++; end
    if (received !== 1'b0) begin checks++; $display("FAIL reset_received: got %b expected 0", received); end else begin checks++; passed++; end
    if (frame_err !== 1'b0) begin checks++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end else begin checks++; passed++; end
    if (busy !== 1'b0) begin checks++; $display("FAIL reset_busy: got %b expected 0", busy); end else begin checks++; passed++; end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    int r0, f0, t0, lat;
    r0 = rcv_cnt; f0 = fe_cnt; t0 = cyc;
    send_frame(8'hA5, 1'b1, -1);
    repeat (4) @(negedge clk);
    lat = last_rcv_cyc - t0;
    if (rcv_cnt - r0 !== 1) begin checks++; $display("FAIL single_count: got %0d expected 1", rcv_cnt - r0); end else begin checks++; passed++; end
    if (rx_byte !== 8'hA5) begin checks++; $display("FAIL single_byte: got %0h expected a5", rx_byte); end else begin checks++; passed++; end
    if (fe_cnt - f0 !== 0) begin checks++; $display("FAIL single_ferr: got %0d expected 0", fe_cnt - f0); end else begin checks++; passed++; end
    if (busy !== 1'b0) begin checks++; $display("FAIL single_busy: got %b expected 0", busy); end else begin checks++; passed++; end
    // 2 sync + 9*16 + 8 + 1 = 155, +/-1
    if (lat < 154 || lat > 156) begin checks++; $display("FAIL single_latency: got %0d expected 155+/-1", lat); end else begin checks++; passed++; end
  endtask

  task automatic test_back_to_back;
    int r0, f0;
    r0 = rcv_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    repeat (4) @(negedge clk);
    if (rcv_cnt - r0 !== 2) begin checks++; $display("FAIL b2b_count: got %0d expected 2", rcv_cnt - r0); end else begin checks++; passed++; end
    if (got[r0] !== 8'h55) begin checks++; $display("FAIL b2b_first: got %0h expected 55", got[r0]); end else begin checks++; passed++; end
    if (got[r0+1] !== 8'h0F) begin checks++; $display("FAIL b2b_second: got %0h expected 0f", got[r0+1]); end else begin checks++; passed++; end
    if (fe_cnt - f0 !== 0) begin checks++; $display("FAIL b2b_ferr: got %0d expected 0", fe_cnt - f0); end else begin checks++; passed++; end
  endtask

  task automatic test_glitch;
    int r0, f0, b0;
    r0 = rcv_cnt; f0 = fe_cnt; b0 = busy_cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    if (rcv_cnt - r0 !== 0) begin checks++; $display("FAIL glitch_received: got %0d expected 0", rcv_cnt - r0); end else begin checks++; passed++; end
    if (fe_cnt - f0 !== 0) begin checks++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cnt - f0); end else begin checks++; passed++; end
    if (busy_cyc - b0 > CPB / 2 + 2 || busy_cyc - b0 < 1) begin checks++; $display("FAIL glitch_busy_len: got %0d expected 1..%0d", busy_cyc - b0, CPB / 2 + 2); end else begin checks++; passed++; end
    if (busy !== 1'b0) begin checks++; $display("FAIL glitch_idle: got %b expected 0", busy); end else begin checks++; passed++; end
  endtask

  task automatic test_frame_error;
    int r0, f0;
    r0 = rcv_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    if (fe_cnt - f0 !== 1) begin checks++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - f0); end else begin checks++; passed++; end
    if (rcv_cnt - r0 !== 0) begin checks++; $display("FAIL ferr_received: got %0d expected 0", rcv_cnt - r0); end else begin checks++; passed++; end
    if (rx_byte !== 8'h0F) begin checks++; $display("FAIL ferr_hold_byte: got %0h expected 0f", rx_byte); end else begin checks++; passed++; end
    if (busy !== 1'b1) begin checks++; $display("FAIL ferr_busy_low: got %b expected 1", busy); end else begin checks++; passed++; end
    rx = 1'b1;
    repeat (6) @(negedge clk);
    if (busy !== 1'b0) begin checks++; $display("FAIL ferr_idle: got %b expected 0", busy); end else begin checks++; passed++; end
    if (fe_cnt - f0 !== 1) begin checks++; $display("FAIL ferr_no_extra: got %0d expected 1", fe_cnt - f0); end else begin checks++; passed++; end
  endtask

  task automatic test_reset_midframe;
    int r0, f0;
    r0 = rcv_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6 * CPB) @(negedge clk);
    if (rx_byte !== 8'h00) begin checks++; $display("FAIL rstmid_byte: got %0h expected 0", rx_byte); end else begin checks++; passed++; end
    if (rcv_cnt - r0 !== 0 || fe_cnt - f0 !== 0) begin checks++; $display("FAIL rstmid_strobe: got %0d expected 0", (rcv_cnt - r0) + (fe_cnt - f0)); end else begin checks++; passed++; end
    if (busy !== 1'b0) begin checks++; $display("FAIL rstmid_busy: got %b expected 0", busy); end else begin checks++; passed++; end
    send_frame(8'h81, 1'b1, -1);
    repeat (4) @(negedge clk);
    if (rcv_cnt - r0 !== 1) begin checks++; $display("FAIL rstmid_next_count: got %0d expected 1", rcv_cnt - r0); end else begin checks++; passed++; end
    if (rx_byte !== 8'h81) begin checks++; $display("FAIL rstmid_next_byte: got %0h expected 81", rx_byte); end else begin checks++; passed++; end
  endtask

  task automatic test_spike;
    int r0, f0;
    r0 = rcv_cnt; f0 = fe_cnt;
    send_frame(8'h00, 1'b1, 3);
    repeat (4) @(negedge clk);
    if (rcv_cnt - r0 !== 1) begin checks++; $display("FAIL spike_count: got %0d expected 1", rcv_cnt - r0); end else begin checks++; passed++; end
    if (rx_byte !== 8'h00) begin checks++; $display("FAIL spike_byte: got %0h expected 0", rx_byte); end else begin checks++; passed++; end
    if (fe_cnt - f0 !== 0) begin checks++; $display("FAIL spike_ferr: got %0d expected 0", fe_cnt - f0); end else begin checks++; passed++; end
  endtask

  task automatic test_strobe_rules;
    if (viol !== 0) begin checks++; $display("FAIL strobe_overlap: got %0d expected 0", viol); end else begin checks++; passed++; end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_reset_midframe;
    test_spike;
    test_strobe_rules;
    chk("total_frames", rcv_cnt, 5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
